pe_row_conv: RTL

Parametrised row-stationary processing element for the Eyeriss PE array. Accepts one filter row (S taps), one ifmap row (W pixels) and E = W−S+1 incoming partial sums. It computes the 1-D convolution one output per cycle and returns the updated partial sums. It also forwards the latched filter and ifmap rows to neighbouring PEs. It generalises the fixed 3-tap / 7-pixel PE with configurable widths and sizes, signed saturating arithmetic, an accumulate/clear mode and a start/ready handshake.

---
 rtl/pe_row_conv.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pe_row_conv.sv
// Row-stationary PE: latches one filter row, one ifmap row and E partial sums,
// then produces one 1-D convolution output per cycle (E = W-S+1 outputs).
// Latched rows are forwarded to neighbouring PEs; results saturate or wrap.
module pe_row_conv #(
    parameter int DW  = 16,
    parameter int PW  = 16,
    parameter int S   = 3,
    parameter int W   = 7,
    parameter int SAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_acc_en,
    output logic                  o_ready,
    input  logic [S*DW-1:0]       i_filt_in,
    input  logic [W*DW-1:0]       i_ifmap_in,
    input  logic [(W-S+1)*PW-1:0] i_psum_in,
    output logic [S*DW-1:0]       o_filt_out,
    output logic [W*DW-1:0]       o_ifmap_out,
    output logic [(W-S+1)*PW-1:0] o_psum_out,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int E    = W - S + 1;
    localparam int KW   = (E > 1) ? $clog2(E) : 1;
    localparam int LS   = (S > 1) ? $clog2(S) : 0;
    localparam int AW   = 2*DW + LS + 1;
    // One extra bit beyond the wider of product-sum and psum keeps the
    // sum exact before saturation/wrap.
    localparam int SUMW = ((AW > PW) ? AW : PW) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_COMP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic signed [SUMW-1:0] MAXV = {{(SUMW-PW+1){1'b0}}, {(PW-1){1'b1}}};
    localparam logic signed [SUMW-1:0] MINV = {{(SUMW-PW+1){1'b1}}, {(PW-1){1'b0}}};

    logic [1:0]       r_state;
    logic [KW-1:0]    r_k;
    logic [S*DW-1:0]  r_filt;
    logic [W*DW-1:0]  r_ifmap;
    logic [E*PW-1:0]  r_psum;

    logic             w_accept;
    logic             w_comp;
    logic             w_last;
    logic [W*DW-1:0]  w_ifmap_sh;
    logic [E*PW-1:0]  w_psum_sh;
    logic [PW-1:0]    w_psum_k;
    logic signed [2*DW-1:0] w_fa   [S];
    logic signed [2*DW-1:0] w_xb   [S];
    logic signed [2*DW-1:0] w_prod [S];
    logic signed [SUMW-1:0] w_sum;
    logic [PW-1:0]    w_res;

    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_comp   = (r_state == ST_COMP);
    assign w_last   = (r_k == KW'(E-1));

    // Slide the ifmap window and select the psum for the current output k.
    assign w_ifmap_sh = r_ifmap >> (r_k * DW);
    assign w_psum_sh  = r_psum >> (r_k * PW);
    assign w_psum_k   = w_psum_sh[PW-1:0];

    // One full-width signed multiplier per tap.
    for (genvar gi = 0; gi < S; gi++) begin : g_tap
        assign w_fa[gi]   = {{DW{r_filt[gi*DW+DW-1]}}, r_filt[gi*DW +: DW]};
        assign w_xb[gi]   = {{DW{w_ifmap_sh[gi*DW+DW-1]}}, w_ifmap_sh[gi*DW +: DW]};
        assign w_prod[gi] = w_fa[gi] * w_xb[gi];
    end

    // Sign-extended psum plus all tap products.
    always_comb begin
        w_sum = {{(SUMW-PW){w_psum_k[PW-1]}}, w_psum_k};
        for (int i = 0; i < S; i++) begin
            w_sum = w_sum + {{(SUMW-2*DW){w_prod[i][2*DW-1]}}, w_prod[i]};
        end
    end

    // Clamp to the PW-bit signed range, or keep the low bits when wrapping.
    always_comb begin
        w_res = w_sum[PW-1:0];
        if (SAT != 0) begin
            if (w_sum > MAXV) begin
                w_res = MAXV[PW-1:0];
            end else if (w_sum < MINV) begin
                w_res = MINV[PW-1:0];
            end
        end
    end

    // Control FSM, output counter and latched row registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_filt  <= '0;
            r_ifmap <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_filt  <= i_filt_in;
                        r_ifmap <= i_ifmap_in;
                        r_k     <= '0;
                        r_state <= ST_COMP;
                    end
                end
                ST_COMP: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Partial sums: loaded on accept, then updated one element per COMP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psum <= '0;
        end else if (w_accept) begin
            r_psum <= i_acc_en ? i_psum_in : '0;
        end else if (w_comp) begin
            r_psum[r_k*PW +: PW] <= w_res;
        end
    end

    assign o_ready     = (r_state == ST_IDLE);
    assign o_busy      = (r_state == ST_COMP) || (r_state == ST_DONE);
    assign o_done      = (r_state == ST_DONE);
    assign o_filt_out  = r_filt;
    assign o_ifmap_out = r_ifmap;
    assign o_psum_out  = r_psum;

endmodule
